pec_tcdm_responder: RTL

- Synthesizable single-bank TCDM slave memory that answers the PEC streamer's TCDM masters (source read port, sink write port).
- Used in the standalone PEC testbench and in FPGA bring-up in place of the cluster interconnect.
- Arbitrates NB_PORTS master ports round-robin, one access per cycle, and returns responses after a fixed configurable latency.
- Optional grant stalls exercise streamer back-pressure; the block keeps access statistics and an error flag.

---
 rtl/pec_tcdm_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pec_tcdm_responder.sv
// ----------------------------------------------------------------------------
// pec_tcdm_responder
//   Single-bank TCDM slave memory standing in for the cluster interconnect
//   in front of the PEC streamer. NB_PORTS masters are arbitrated
//   round-robin, one access per cycle. Every granted access (read or write)
//   is answered LATENCY cycles after its grant.
//
// Ports
//   clk_i, rst_ni   clock, async active-low reset
//   clear_i         soft clear: flush responses, zero counters/err, rr -> 0
//   stall_i         per-port grant inhibit
//   req_i/add_i/wen_i/be_i/wdata_i   TCDM request per port (wen 1 = read)
//   gnt_o           combinational grant, one-hot or zero
//   r_valid_o       one-cycle response pulse per port
//   r_rdata_o       response data, held between pulses
//   rd_cnt_o/wr_cnt_o  saturating granted-access counters
//   err_o           sticky out-of-range flag
// ----------------------------------------------------------------------------

// Per-port response output: passes the pulse through and keeps the last
// delivered word visible between pulses.
module pec_tcdm_resp_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_hold <= '0;
        else if (i_vld) r_hold <= i_data;
    end

    assign o_valid = i_vld;
    assign o_rdata = i_vld ? i_data : r_hold;
endmodule

module pec_tcdm_responder #(
    parameter int                    NB_PORTS   = 2,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    LATENCY    = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clear_i,
    input  logic [NB_PORTS-1:0]                    stall_i,
    input  logic [NB_PORTS-1:0]                    req_i,
    input  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0]    add_i,
    input  logic [NB_PORTS-1:0]                    wen_i,
    input  logic [NB_PORTS-1:0][DATA_WIDTH/8-1:0]  be_i,
    input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
    output logic [NB_PORTS-1:0]                    gnt_o,
    output logic [NB_PORTS-1:0][DATA_WIDTH-1:0]    r_rdata_o,
    output logic [NB_PORTS-1:0]                    r_valid_o,
    output logic [31:0]                            rd_cnt_o,
    output logic [31:0]                            wr_cnt_o,
    output logic                                   err_o
);
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(BE_W);
    localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PORT_W = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam logic [ADDR_WIDTH:0]   MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS * BE_W);
    localparam logic [DATA_WIDTH-1:0] ERR_WORD  = {(DATA_WIDTH/32){32'hDEADBEEF}};

    typedef struct packed {
        logic                  vld;
        logic [PORT_W-1:0]     port;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("pec_tcdm_responder: LATENCY must be 1..4");
        end
        if (NB_PORTS < 1) begin : g_bad_ports
            $error("pec_tcdm_responder: NB_PORTS must be >= 1");
        end
        if (MEM_WORDS < 1 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
            $error("pec_tcdm_responder: MEM_WORDS must be a power of two");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    resp_t                 r_pipe [LATENCY];
    logic [PORT_W-1:0]     r_rr;
    logic [31:0]           r_rd_cnt, r_wr_cnt;
    logic                  r_err;

    logic [NB_PORTS-1:0]   w_elig, w_gnt;
    logic [PORT_W-1:0]     w_win, w_cand;
    logic                  w_any;

    // Clear also blocks all grants so nothing is accepted in the clear cycle.
    assign w_elig = req_i & ~stall_i & {NB_PORTS{~clear_i}};

    // Round-robin scan starting at r_rr, wrapping at NB_PORTS.
    always_comb begin
        w_win  = '0;
        w_any  = 1'b0;
        w_gnt  = '0;
        w_cand = r_rr;
        for (int i = 0; i < NB_PORTS; i++) begin
            if (!w_any && w_elig[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
            w_cand = (w_cand == PORT_W'(NB_PORTS - 1)) ? '0 : w_cand + 1'b1;
        end
        if (w_any) w_gnt[w_win] = 1'b1;
    end
    assign gnt_o = w_gnt;

    logic [ADDR_WIDTH-1:0] w_add, w_off;
    logic                  w_wen, w_in_range;
    logic [BE_W-1:0]       w_be;
    logic [DATA_WIDTH-1:0] w_wdata, w_rd_word;
    logic [IDX_W-1:0]      w_idx;

    assign w_add      = add_i[w_win];
    assign w_wen      = wen_i[w_win];
    assign w_be       = be_i[w_win];
    assign w_wdata    = wdata_i[w_win];
    assign w_off      = w_add - BASE_ADDR;
    assign w_in_range = (w_add >= BASE_ADDR) && ({1'b0, w_off} < MEM_BYTES);
    assign w_idx      = IDX_W'(w_off >> OFF_W);
    // Sampled before the write lands, so writes return the old contents.
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : ERR_WORD;

    always_ff @(posedge clk_i) begin
        if (w_any && !w_wen && w_in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < LATENCY; k++) r_pipe[k] <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < LATENCY; k++) r_pipe[k].vld <= 1'b0;
        end else begin
            r_pipe[0] <= '{vld: w_any, port: w_win, data: w_rd_word};
            for (int k = 1; k < LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr     <= '0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_err    <= 1'b0;
        end else if (clear_i) begin
            r_rr     <= '0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_err    <= 1'b0;
        end else if (w_any) begin
            r_rr <= (w_win == PORT_W'(NB_PORTS - 1)) ? '0 : w_win + 1'b1;
            if (w_wen) begin
                if (!(&r_rd_cnt)) r_rd_cnt <= r_rd_cnt + 32'd1;
            end else begin
                if (!(&r_wr_cnt)) r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if (!w_in_range) r_err <= 1'b1;
        end
    end

    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;
    assign err_o    = r_err;

    for (genvar p = 0; p < NB_PORTS; p++) begin : g_lane
        logic w_lane_vld;
        assign w_lane_vld = r_pipe[LATENCY-1].vld && (r_pipe[LATENCY-1].port == PORT_W'(p));
        pec_tcdm_resp_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_vld   (w_lane_vld),
            .i_data  (r_pipe[LATENCY-1].data),
            .o_valid (r_valid_o[p]),
            .o_rdata (r_rdata_o[p])
        );
    end
endmodule
